cordic_round_sched: RTL

CORDIC_ROUND_SCHED -- requirements
Module: cordic_round_sched

---
 rtl/cordic_round_sched_pkg.sv | 10 +
 rtl/cordic_rnd_core.sv | 17 +
 rtl/cordic_round_sched.sv | 101 ++++++++++
 3 files changed

// File: rtl/cordic_round_sched_pkg.sv
// cordic_round_sched_pkg: shared FSM states, default sizes and channel-tag width helper
package cordic_round_sched_pkg;
    typedef enum logic [1:0] {EMPTY, RUN, STALL} state_t;
    localparam int DEF_WW = 16;
    localparam int DEF_OW = 13;
    localparam int DEF_NCH = 4;
    function automatic int ch_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/cordic_rnd_core.sv
// cordic_rnd_core: convergent (half-to-even) rounding from WW to OW bits with wrap detection
module cordic_rnd_core #(
    parameter int WW = 16,
    parameter int OW = 13
) (
    input  logic [WW-1:0] din,
    output logic [OW-1:0] dout,
    output logic          ovf
);
    localparam int SH = WW - OW;
    logic [WW-1:0] half, bias, sum;
    assign half = WW'(1) << (SH - 1);
    assign bias = din[SH] ? half : half - WW'(1);
    assign sum = din + bias;
    assign dout = OW'(sum >> SH);
    assign ovf = !din[WW-1] && sum[WW-1];
endmodule

// File: rtl/cordic_round_sched.sv
// cordic_round_sched: round-robin scheduler sharing one two-stage rounding pipe across NCH channels
module cordic_round_sched
    import cordic_round_sched_pkg::*;
#(
    parameter int NCH = DEF_NCH,
    parameter int WW = DEF_WW,
    parameter int OW = DEF_OW
) (
    input  logic                   i_clk,
    input  logic                   i_reset_n,
    input  logic                   i_ce,
    input  logic [NCH-1:0]         i_valid,
    output logic [NCH-1:0]         o_ready,
    input  logic [NCH*WW-1:0]      i_x,
    input  logic [NCH*WW-1:0]      i_y,
    output logic                   o_valid,
    input  logic                   i_ready,
    output logic [ch_w(NCH)-1:0]   o_ch,
    output logic [OW-1:0]          o_xval,
    output logic [OW-1:0]          o_yval,
    output logic                   o_ovf
);
    localparam int CW = ch_w(NCH);
    state_t state, state_nxt;
    logic [CW-1:0] ptr, gidx, iss_ch;
    logic [NCH-1:0] gnt;
    logic [WW-1:0] iss_x, iss_y;
    logic [OW-1:0] x_rnd, y_rnd;
    logic iss_v, out_free, iss_free, can_issue, accept, x_ovf, y_ovf, nxt_iv, nxt_ov;
    int idx;

    assign out_free = !o_valid || i_ready;
    assign iss_free = !iss_v || out_free;
    assign accept = |o_ready;

    // scanning from farthest to nearest lets the channel just after ptr win
    always_comb begin
        gnt = '0;
        gidx = ptr;
        idx = 0;
        for (int i = NCH; i >= 1; i--) begin
            idx = (int'(ptr) + i) % NCH;
            if (i_valid[idx]) begin
                gnt = '0;
                gnt[idx] = 1'b1;
                gidx = CW'(idx);
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) state <= EMPTY;
        else if (i_ce) state <= state_nxt;
    end

    always_comb begin
        nxt_iv = iss_free ? accept : 1'b1;
        nxt_ov = out_free ? iss_v : 1'b1;
        state_nxt = (nxt_iv && nxt_ov && !out_free) ? STALL : (nxt_iv || nxt_ov) ? RUN : EMPTY;
    end

    always_comb begin
        can_issue = i_reset_n && i_ce && iss_free && (state != STALL || i_ready);
        o_ready = can_issue ? gnt : '0;
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            ptr <= CW'(NCH - 1);
            iss_v <= 1'b0;
            iss_ch <= '0;
            iss_x <= '0;
            iss_y <= '0;
            o_valid <= 1'b0;
            o_ch <= '0;
            o_xval <= '0;
            o_yval <= '0;
            o_ovf <= 1'b0;
        end else if (i_ce) begin
            if (out_free) begin
                o_valid <= iss_v;
                if (iss_v) begin
                    o_ch <= iss_ch;
                    o_xval <= x_rnd;
                    o_yval <= y_rnd;
                    o_ovf <= x_ovf || y_ovf;
                end
            end
            if (iss_free) iss_v <= accept;
            if (accept) begin
                ptr <= gidx;
                iss_ch <= gidx;
                iss_x <= i_x[int'(gidx)*WW +: WW];
                iss_y <= i_y[int'(gidx)*WW +: WW];
            end
        end
    end

    cordic_rnd_core #(.WW(WW), .OW(OW)) u_rnd_x (.din(iss_x), .dout(x_rnd), .ovf(x_ovf));
    cordic_rnd_core #(.WW(WW), .OW(OW)) u_rnd_y (.din(iss_y), .dout(y_rnd), .ovf(y_ovf));
endmodule
